// File: rtl/rr_grant_controller_pkg.sv
// Shared types for the round-robin grant controller.
package rr_grant_pkg;

    // Arbiter state: nobody holds the resource, or one requester does.
    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_grant_controller_encoder_onehot.sv
// One-hot to binary encoder. Each index bit is the OR of every one-hot
// position whose binary position number has that bit set; valid flags a
// non-zero input so the caller can mask the index when nothing is set.
module encoder_onehot #(
    parameter int NUM_BITS     = 4,
    parameter int LOG_NUM_BITS = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
    input  logic [NUM_BITS-1:0]     onehot,
    output logic [LOG_NUM_BITS-1:0] index,
    output logic                    valid
);

    generate
        for (genvar gi = 0; gi < LOG_NUM_BITS; gi++) begin : g_bit
            logic [NUM_BITS-1:0] sel;
            for (genvar gj = 0; gj < NUM_BITS; gj++) begin : g_pos
                localparam logic [31:0] POS = gj;
                assign sel[gj] = POS[gi] ? onehot[gj] : 1'b0;
            end
            assign index[gi] = |sel;
        end
    endgenerate

    assign valid = |onehot;

endmodule

// File: rtl/rr_grant_controller.sv
// Round-robin grant controller: shares one resource among NUM_REQS
// requesters, holding each grant until release, abort or hold timeout,
// and hands over to the next winner without an idle bubble.
module rr_grant_controller
    import rr_grant_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int LOG_NUM_REQS = $clog2(NUM_REQS),
    parameter int MAX_HOLD     = 8,
    parameter int LOG_MAX_HOLD = $clog2(MAX_HOLD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQS-1:0]     i__request,
    input  logic                    i__release,
    output logic [NUM_REQS-1:0]     o__grant,
    output logic                    o__grant_valid,
    output logic [LOG_NUM_REQS-1:0] o__grant_index,
    output logic                    o__timeout
);

    state_t                  state_reg;
    logic [NUM_REQS-1:0]     grant_reg;
    logic                    grant_valid_reg;
    logic                    timeout_reg;
    logic [LOG_NUM_REQS-1:0] ptr_reg;
    logic [LOG_MAX_HOLD-1:0] hold_reg;

    logic [LOG_NUM_REQS-1:0] enc_index;
    logic                    enc_valid;

    logic                    end_release;
    logic                    end_abort;
    logic                    end_hold;
    logic                    grant_end;
    logic [LOG_NUM_REQS-1:0] ptr_after;
    logic [NUM_REQS-1:0]     idle_winner;
    logic [NUM_REQS-1:0]     rearb_winner;

    // First set request at or after ptr, wrapping; returns a one-hot vector.
    function automatic logic [NUM_REQS-1:0] pick_winner(
        input logic [NUM_REQS-1:0]     req,
        input logic [LOG_NUM_REQS-1:0] ptr
    );
        logic [NUM_REQS-1:0]     win;
        logic [LOG_NUM_REQS-1:0] idx;
        logic                    found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = LOG_NUM_REQS'((int'(ptr) + k) % NUM_REQS);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return win;
    endfunction

    // The grantee's index doubles as the basis for the next pointer.
    encoder_onehot #(
        .NUM_BITS     (NUM_REQS),
        .LOG_NUM_BITS (LOG_NUM_REQS)
    ) u_encoder (
        .onehot (grant_reg),
        .index  (enc_index),
        .valid  (enc_valid)
    );

    // Grant-end causes and the two candidate winners (fresh and handover).
    always_comb begin
        end_release  = i__release;
        end_abort    = ~|(grant_reg & i__request);
        end_hold     = (hold_reg == LOG_MAX_HOLD'(MAX_HOLD - 1));
        grant_end    = end_release | end_abort | end_hold;
        ptr_after    = (enc_index == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0 : enc_index + 1'b1;
        idle_winner  = pick_winner(i__request, ptr_reg);
        rearb_winner = pick_winner(i__request & ~grant_reg, ptr_after);
    end

    // Arbitration FSM with registered grant, valid and timeout outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            ptr_reg         <= '0;
            hold_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout_reg <= 1'b0;
                    hold_reg    <= '0;
                    if (|i__request) begin
                        grant_reg       <= idle_winner;
                        grant_valid_reg <= 1'b1;
                        state_reg       <= GRANTED;
                    end else begin
                        grant_reg       <= '0;
                        grant_valid_reg <= 1'b0;
                    end
                end
                GRANTED: begin
                    if (grant_end) begin
                        ptr_reg     <= ptr_after;
                        hold_reg    <= '0;
                        timeout_reg <= end_hold & ~end_release & ~end_abort;
                        if (|rearb_winner) begin
                            grant_reg       <= rearb_winner;
                            grant_valid_reg <= 1'b1;
                        end else begin
                            grant_reg       <= '0;
                            grant_valid_reg <= 1'b0;
                            state_reg       <= IDLE;
                        end
                    end else begin
                        timeout_reg <= 1'b0;
                        if (hold_reg != LOG_MAX_HOLD'(MAX_HOLD)) begin
                            hold_reg <= hold_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    grant_reg       <= '0;
                    grant_valid_reg <= 1'b0;
                    timeout_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign o__grant       = grant_reg;
    assign o__grant_valid = grant_valid_reg;
    assign o__grant_index = enc_valid ? enc_index : '0;
    assign o__timeout     = timeout_reg;

endmodule
